// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS-style control unit: state codes,
// instruction opcode/funct values and the datapath mux/ALU select codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JR       = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Funct codes (IR[5:0]) that change control behaviour
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;

  // ALU operation select
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_SLT   = 3'b100;
  localparam logic [2:0] ALUOP_SLTU  = 3'b101;

  // ALU B operand select
  localparam logic [1:0] ALUSRCB_REGB   = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_LU     = 2'b10;
  localparam logic [1:0] ALUSRCB_LU_SH2 = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  // Destination register select
  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  // Register write-back source select
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // Shift-by-shamt R-types take the shift amount path on ALU input A.
  function automatic logic is_shamt_shift(input logic [5:0] fn);
    return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational output decode for the multicycle control FSM. Everything
// except the FETCH handshake strobes is a function of state and IR fields.
module mc_decode
  import mc_pkg::*;
(
  input  logic [3:0] State,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       ExtOp,
  output logic       LuOp,
  output logic       Illegal,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg
);

  state_t st;
  assign st = state_t'(State);

  // Per-state control word; anything a state does not name stays at zero.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    ExtOp       = 1'b0;
    LuOp        = 1'b0;
    Illegal     = 1'b0;
    ALUSrcB     = ALUSRCB_REGB;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    RegDst      = REGDST_RT;
    MemtoReg    = M2R_ALUOUT;
    case (st)
      S_FETCH: begin
        // IR and PC+4 are captured only on the cycle memory delivers.
        MemRead = 1'b1;
        IRWrite = MemReady;
        PCWrite = MemReady;
        ALUSrcB = ALUSRCB_FOUR;
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut.
        ALUSrcB = ALUSRCB_LU_SH2;
        ExtOp   = 1'b1;
      end
      S_MEM_ADDR: begin
        ALUSrcB = ALUSRCB_LU;
        ExtOp   = 1'b1;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        RegDst   = REGDST_RT;
        MemtoReg = M2R_MDR;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA = is_shamt_shift(Funct);
        ALUSrcB = ALUSRCB_REGB;
        ALUOp   = ALUOP_FUNCT;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = REGDST_RD;
        MemtoReg = M2R_ALUOUT;
      end
      S_EXEC_I: begin
        ALUSrcB = ALUSRCB_LU;
        ExtOp   = (OpCode != OP_ANDI);
        LuOp    = (OpCode == OP_LUI);
        case (OpCode)
          OP_ANDI:  ALUOp = ALUOP_AND;
          OP_SLTI:  ALUOp = ALUOP_SLT;
          OP_SLTIU: ALUOp = ALUOP_SLTU;
          default:  ALUOp = ALUOP_ADD;
        endcase
      end
      S_I_WB: begin
        RegWrite = 1'b1;
        RegDst   = REGDST_RT;
        MemtoReg = M2R_ALUOUT;
      end
      S_BRANCH: begin
        // Datapath qualifies PCWriteCond with the ALU Zero flag.
        ALUSrcB     = ALUSRCB_REGB;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
        if (OpCode == OP_JAL) begin
          RegWrite = 1'b1;
          RegDst   = REGDST_RA;
          MemtoReg = M2R_PC;
        end
      end
      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_REGA;
      end
      S_TRAP: begin
        Illegal = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control unit: Moore FSM state register and sequencing, with the
// output decode in mc_decode. Reset forces the FETCH decode and suppresses
// every write enable for as long as it is held.
module multicycle_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       ExtOp,
  output logic       LuOp,
  output logic       Illegal,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [3:0] State
);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] dec_state;
  logic       dec_pc_write;
  logic       dec_pc_write_cond;
  logic       dec_mem_write;
  logic       dec_reg_write;
  logic       dec_ir_write;

  // Zero is consumed by the datapath together with PCWriteCond.
  logic unused_zero;
  assign unused_zero = Zero;

  // State register; reset wins over any wait, trap or in-flight instruction.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state sequencing; memory states stall until MemReady.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (OpCode)
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_RTYPE:      state_d = (Funct == FN_JR) ? S_JR : S_EXEC_R;
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_LUI:
                         state_d = S_EXEC_I;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J, OP_JAL:  state_d = S_JUMP;
          default:       state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        if (OpCode == OP_LW)      state_d = S_MEM_RD;
        else if (OpCode == OP_SW) state_d = S_MEM_WR;
        else                      state_d = S_TRAP;
      end
      S_MEM_RD:   if (MemReady) state_d = S_MEM_WB;
      S_MEM_WR:   if (MemReady) state_d = S_FETCH;
      S_EXEC_R:   state_d = S_R_WB;
      S_EXEC_I:   state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JR:
                  state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  assign dec_state = reset ? S_FETCH : state_q;

  mc_decode u_decode (
    .State       (dec_state),
    .OpCode      (OpCode),
    .Funct       (Funct),
    .MemReady    (MemReady),
    .PCWrite     (dec_pc_write),
    .PCWriteCond (dec_pc_write_cond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (dec_mem_write),
    .IRWrite     (dec_ir_write),
    .ALUSrcA     (ALUSrcA),
    .RegWrite    (dec_reg_write),
    .ExtOp       (ExtOp),
    .LuOp        (LuOp),
    .Illegal     (Illegal),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg)
  );

  assign PCWrite     = dec_pc_write      & ~reset;
  assign PCWriteCond = dec_pc_write_cond & ~reset;
  assign MemWrite    = dec_mem_write     & ~reset;
  assign RegWrite    = dec_reg_write     & ~reset;
  assign IRWrite     = dec_ir_write      & ~reset;
  assign State       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle expected state and control word are
// queued for each instruction and compared as the FSM walks through it.
module tb_multicycle_control;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       ALUSrcA, RegWrite, ExtOp, LuOp, Illegal;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSource, RegDst, MemtoReg;
  logic [3:0] State;

  multicycle_control dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .ExtOp(ExtOp), .LuOp(LuOp),
    .Illegal(Illegal), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .RegDst(RegDst), .MemtoReg(MemtoReg), .State(State)
  );

  always #5 clk = ~clk;

  typedef logic [21:0] word_t;

  typedef struct {
    logic [5:0]      op;
    logic [5:0]      fn;
    logic            zero;
    int              len;
    logic [4:0][3:0] seq;
    word_t           w2;
  } vec_t;

  typedef struct {
    logic [3:0] st;
    word_t      w;
  } exp_t;

  exp_t  sbq[$];
  vec_t  vt[16];
  int    nvec;
  int    nchk  = 0;
  int    npass = 0;
  logic  mw_seen;
  int    mwcnt;

  word_t act;
  assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, ALUSrcA,
                RegWrite, ExtOp, LuOp, Illegal, ALUSrcB, ALUOp, PCSource,
                RegDst, MemtoReg};

  // Field order: pcw pcwc iord mrd mwr irw asa rw ext lu ill asb aop pcs rd m2r
  function automatic word_t cw(input int pcw, pcwc, iord, mrd, mwr, irw, asa,
                               rw, ext, lu, ill, asb, aop, pcs, rd, m2r);
    return {pcw[0], pcwc[0], iord[0], mrd[0], mwr[0], irw[0], asa[0], rw[0],
            ext[0], lu[0], ill[0], asb[1:0], aop[2:0], pcs[1:0], rd[1:0],
            m2r[1:0]};
  endfunction

  function automatic logic [4:0][3:0] sq(input logic [3:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  word_t W_F, W_FW, W_D, W_MA, W_MRD, W_MWB, W_MWR, W_RWB, W_IWB, W_TRAP;
  word_t W_ER, W_ERSH, W_EIADD, W_EIAND, W_EISLT, W_EISLTU, W_EILUI;
  word_t W_BR, W_J, W_JAL, W_JR;

  // Words for states whose control does not depend on the instruction.
  function automatic word_t cmn(input logic [3:0] s);
    case (s)
      S_FETCH:    return W_F;
      S_DECODE:   return W_D;
      S_MEM_ADDR: return W_MA;
      S_MEM_RD:   return W_MRD;
      S_MEM_WB:   return W_MWB;
      S_MEM_WR:   return W_MWR;
      S_R_WB:     return W_RWB;
      S_I_WB:     return W_IWB;
      S_TRAP:     return W_TRAP;
      default:    return '0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    nchk++;
    if (got === want) npass++;
    else $display("FAIL %s got %0h want %0h", nm, got, want);
  endtask

  task automatic push(input logic [3:0] st, input word_t w);
    exp_t e;
    e.st = st;
    e.w  = w;
    sbq.push_back(e);
  endtask

  task automatic step(input string nm);
    exp_t e;
    @(negedge clk);
    mw_seen = MemWrite;
    if (sbq.size() == 0) begin
      nchk++;
      $display("FAIL %s scoreboard empty got state %0d", nm, State);
    end else begin
      e = sbq.pop_front();
      check($sformatf("%s state", nm), 32'(State), 32'(e.st));
      check($sformatf("%s ctl", nm), 32'(act), 32'(e.w));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    W_F      = cw(1,0,0,1,0,1,0,0,0,0,0, 1,0,0,0,0);
    W_FW     = cw(0,0,0,1,0,0,0,0,0,0,0, 1,0,0,0,0);
    W_D      = cw(0,0,0,0,0,0,0,0,1,0,0, 3,0,0,0,0);
    W_MA     = cw(0,0,0,0,0,0,0,0,1,0,0, 2,0,0,0,0);
    W_MRD    = cw(0,0,1,1,0,0,0,0,0,0,0, 0,0,0,0,0);
    W_MWB    = cw(0,0,0,0,0,0,0,1,0,0,0, 0,0,0,0,1);
    W_MWR    = cw(0,0,1,0,1,0,0,0,0,0,0, 0,0,0,0,0);
    W_RWB    = cw(0,0,0,0,0,0,0,1,0,0,0, 0,0,0,1,0);
    W_IWB    = cw(0,0,0,0,0,0,0,1,0,0,0, 0,0,0,0,0);
    W_TRAP   = cw(0,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0);
    W_ER     = cw(0,0,0,0,0,0,0,0,0,0,0, 0,2,0,0,0);
    W_ERSH   = cw(0,0,0,0,0,0,1,0,0,0,0, 0,2,0,0,0);
    W_EIADD  = cw(0,0,0,0,0,0,0,0,1,0,0, 2,0,0,0,0);
    W_EIAND  = cw(0,0,0,0,0,0,0,0,0,0,0, 2,3,0,0,0);
    W_EISLT  = cw(0,0,0,0,0,0,0,0,1,0,0, 2,4,0,0,0);
    W_EISLTU = cw(0,0,0,0,0,0,0,0,1,0,0, 2,5,0,0,0);
    W_EILUI  = cw(0,0,0,0,0,0,0,0,1,1,0, 2,0,0,0,0);
    W_BR     = cw(0,1,0,0,0,0,0,0,0,0,0, 0,1,1,0,0);
    W_J      = cw(1,0,0,0,0,0,0,0,0,0,0, 0,0,2,0,0);
    W_JAL    = cw(1,0,0,0,0,0,0,1,0,0,0, 0,0,2,2,2);
    W_JR     = cw(1,0,0,0,0,0,0,0,0,0,0, 0,0,3,0,0);

    vt[0]  = '{6'h23, 6'h00, 1'b0, 5, sq(S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB), W_MA};
    vt[1]  = '{6'h2B, 6'h00, 1'b0, 4, sq(S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_WR, S_FETCH), W_MA};
    vt[2]  = '{6'h00, 6'h20, 1'b0, 4, sq(S_FETCH, S_DECODE, S_EXEC_R, S_R_WB, S_FETCH), W_ER};
    vt[3]  = '{6'h00, 6'h00, 1'b0, 4, sq(S_FETCH, S_DECODE, S_EXEC_R, S_R_WB, S_FETCH), W_ERSH};
    vt[4]  = '{6'h00, 6'h03, 1'b0, 4, sq(S_FETCH, S_DECODE, S_EXEC_R, S_R_WB, S_FETCH), W_ERSH};
    vt[5]  = '{6'h00, 6'h2A, 1'b0, 4, sq(S_FETCH, S_DECODE, S_EXEC_R, S_R_WB, S_FETCH), W_ER};
    vt[6]  = '{6'h08, 6'h00, 1'b0, 4, sq(S_FETCH, S_DECODE, S_EXEC_I, S_I_WB, S_FETCH), W_EIADD};
    vt[7]  = '{6'h09, 6'h00, 1'b0, 4, sq(S_FETCH, S_DECODE, S_EXEC_I, S_I_WB, S_FETCH), W_EIADD};
    vt[8]  = '{6'h0A, 6'h00, 1'b0, 4, sq(S_FETCH, S_DECODE, S_EXEC_I, S_I_WB, S_FETCH), W_EISLT};
    vt[9]  = '{6'h0B, 6'h00, 1'b0, 4, sq(S_FETCH, S_DECODE, S_EXEC_I, S_I_WB, S_FETCH), W_EISLTU};
    vt[10] = '{6'h0C, 6'h00, 1'b0, 4, sq(S_FETCH, S_DECODE, S_EXEC_I, S_I_WB, S_FETCH), W_EIAND};
    vt[11] = '{6'h0F, 6'h00, 1'b0, 4, sq(S_FETCH, S_DECODE, S_EXEC_I, S_I_WB, S_FETCH), W_EILUI};
    vt[12] = '{6'h04, 6'h00, 1'b1, 3, sq(S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH), W_BR};
    vt[13] = '{6'h04, 6'h00, 1'b0, 3, sq(S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH), W_BR};
    vt[14] = '{6'h03, 6'h00, 1'b0, 3, sq(S_FETCH, S_DECODE, S_JUMP, S_FETCH, S_FETCH), W_JAL};
    vt[15] = '{6'h00, 6'h08, 1'b0, 3, sq(S_FETCH, S_DECODE, S_JR, S_FETCH, S_FETCH), W_JR};
    nvec = 16;

    // Reset with MemReady high: FETCH decode, strobes suppressed.
    reset = 1'b1; MemReady = 1'b1; OpCode = 6'h00; Funct = 6'h00; Zero = 1'b0;
    @(posedge clk);
    #1;
    push(S_FETCH, W_FW);
    step("reset");
    reset = 1'b0;

    // Table of single instructions with memory always ready.
    for (int i = 0; i < nvec; i++) begin
      OpCode = vt[i].op; Funct = vt[i].fn; Zero = vt[i].zero; MemReady = 1'b1;
      for (int c = 0; c < vt[i].len; c++)
        push(vt[i].seq[3'(c)], (c == 2) ? vt[i].w2 : cmn(vt[i].seq[3'(c)]));
      for (int c = 0; c < vt[i].len; c++)
        step($sformatf("v%0d c%0d", i, c));
    end

    // j with two FETCH stall cycles.
    OpCode = 6'h02; Funct = 6'h00;
    push(S_FETCH, W_FW); push(S_FETCH, W_FW); push(S_FETCH, W_F);
    push(S_DECODE, W_D); push(S_JUMP, W_J);
    for (int c = 0; c < 5; c++) begin
      MemReady = (c >= 2);
      step($sformatf("jwait c%0d", c));
    end

    // sw with three stall cycles in MEM_WR.
    OpCode = 6'h2B; mwcnt = 0;
    push(S_FETCH, W_F); push(S_DECODE, W_D); push(S_MEM_ADDR, W_MA);
    for (int c = 0; c < 4; c++) push(S_MEM_WR, W_MWR);
    for (int c = 0; c < 7; c++) begin
      MemReady = !(c >= 3 && c <= 5);
      step($sformatf("swwait c%0d", c));
      if (mw_seen) mwcnt++;
    end
    check("sw memwrite cycles", 32'(mwcnt), 32'd4);

    // lw stalled in MEM_RD, then reset mid-instruction.
    OpCode = 6'h23;
    push(S_FETCH, W_F); push(S_DECODE, W_D); push(S_MEM_ADDR, W_MA);
    push(S_MEM_RD, W_MRD); push(S_MEM_RD, W_MRD);
    for (int c = 0; c < 5; c++) begin
      MemReady = (c < 3);
      step($sformatf("lwrst c%0d", c));
    end
    reset = 1'b1; MemReady = 1'b0;
    push(S_MEM_RD, W_FW);
    step("lwrst reset");
    reset = 1'b0; MemReady = 1'b1;
    push(S_FETCH, W_F); push(S_DECODE, W_D); push(S_MEM_ADDR, W_MA);
    push(S_MEM_RD, W_MRD); push(S_MEM_WB, W_MWB);
    for (int c = 0; c < 5; c++) step($sformatf("lwafter c%0d", c));

    // Illegal opcode 0x3F: trap held, only reset escapes.
    OpCode = 6'h3F;
    push(S_FETCH, W_F); push(S_DECODE, W_D);
    for (int c = 0; c < 11; c++) push(S_TRAP, W_TRAP);
    for (int c = 0; c < 13; c++) step($sformatf("trap3f c%0d", c));
    reset = 1'b1;
    push(S_TRAP, W_FW);
    step("trap3f reset");
    reset = 1'b0;

    // ori (0x0D) is not a supported opcode.
    OpCode = 6'h0D;
    push(S_FETCH, W_F); push(S_DECODE, W_D); push(S_TRAP, W_TRAP); push(S_TRAP, W_TRAP);
    for (int c = 0; c < 4; c++) step($sformatf("trap0d c%0d", c));
    reset = 1'b1;
    push(S_TRAP, W_FW);
    step("trap0d reset");
    reset = 1'b0;
    OpCode = 6'h02;
    push(S_FETCH, W_F);
    step("final fetch");

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
